// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered RS-232 transmitter with run-time parity select.
// Words are queued with their parity mode and sent back-to-back on tx.
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | line idle high, waiting for a queued word
// START  | start bit (0) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | parity bit of the latched word (even/odd modes only)
// STOP   | stop bit(s) high; pops the next word on the final cycle
module uart_tx_fifo #(
    parameter int CLK_HZ     = 24_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            parity_mode,
    input  logic [DATA_BITS-1:0]                  in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic                                  tx,
    output logic                                  busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W  = $clog2(DIV);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = DATA_BITS + 2;
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;

    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 full, empty, push, pop, bit_end;
    logic [WORD_W-1:0]    head;
    logic [DATA_BITS-1:0] head_data;
    logic [1:0]           head_mode;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_data  = head[DATA_BITS-1:0];
    assign head_mode  = head[WORD_W-1:DATA_BITS];
    assign bit_end    = (baud_q == CNT_W'(DIV - 1));
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = count_q;

    // FIFO storage, pointers and occupancy; push and pop may share an edge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {parity_mode, in_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Frame sequencing: next state, baud/bit counters, shifter and line level.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = BIT_W'(DATA_BITS - 1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == '0) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                            bit_d   = BIT_W'(STOP_BITS - 1);
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q - 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = BIT_W'(STOP_BITS - 1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == '0) begin
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // A pop latches the head word and its parity choice for the whole frame.
        if (pop) begin
            state_d   = S_START;
            baud_d    = '0;
            shift_d   = head_data;
            par_en_d  = (head_mode == 2'b01) || (head_mode == 2'b10);
            par_bit_d = (head_mode == 2'b10) ? ~^head_data : ^head_data;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // Control registers; reset abandons any frame and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO payload needs no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, FIFO fill and reset.
// u_dut1 uses one stop bit, u_dut2 two stop bits; both at 16 clocks per bit.
module tb_uart_tx_fifo;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pm1, pm2;
    logic [7:0] d1, d2;
    logic       v1, v2;
    logic       rdy1, rdy2, tx1, tx2, busy1, busy2;
    logic [2:0] cnt1, cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .parity_mode(pm1), .in_data(d1), .in_valid(v1),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .fifo_count(cnt1)
    );

    uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .parity_mode(pm2), .in_data(d2), .in_valid(v2),
        .in_ready(rdy2), .tx(tx2), .busy(busy2), .fifo_count(cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Walks one frame from the edge that starts it, checking the first and last
    // cycle of every bit. With started=1 the caller already sits on the first cycle.
    task automatic check_frame(input int sel, input string tag, input logic [7:0] data,
                               input logic [1:0] mode, input int stops, input bit started);
        logic bits[$];
        logic line;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (mode == 2'b01) bits.push_back(^data);
        if (mode == 2'b10) bits.push_back(~^data);
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            if (!(started && b == 0)) tick();
            line = (sel == 2) ? tx2 : tx1;
            check_eq($sformatf("%s bit%0d first", tag, b), 32'(line), 32'(bits[b]));
            repeat (DIV - 1) tick();
            line = (sel == 2) ? tx2 : tx1;
            check_eq($sformatf("%s bit%0d last", tag, b), 32'(line), 32'(bits[b]));
        end
    endtask

    task automatic send1(input logic [7:0] data, input logic [1:0] mode);
        d1  = data;
        pm1 = mode;
        v1  = 1'b1;
        check_eq("send ready", 32'(rdy1), 32'd1);
        tick();
        v1 = 1'b0;
        check_eq("count after accept", 32'(cnt1), 32'd1);
        check_eq("tx idle at accept", 32'(tx1), 32'd1);
        check_eq("busy at accept", 32'(busy1), 32'd1);
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        v1 = 1'b0; v2 = 1'b0;
        d1 = '0;   d2 = '0;
        pm1 = '0;  pm2 = '0;

        // Reset
        repeat (3) tick();
        check_eq("rst tx", 32'(tx1), 32'd1);
        check_eq("rst busy", 32'(busy1), 32'd0);
        check_eq("rst count", 32'(cnt1), 32'd0);
        check_eq("rst ready", 32'(rdy1), 32'd0);
        check_eq("rst ready2", 32'(rdy2), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post rst ready", 32'(rdy1), 32'd1);
        check_eq("post rst tx", 32'(tx1), 32'd1);
        check_eq("post rst busy", 32'(busy1), 32'd0);

        // 8N1 0x55: 160-clock frame, busy falls on the following edge
        send1(8'h55, 2'b00);
        check_frame(1, "8n1", 8'h55, 2'b00, 1, 1'b0);
        check_eq("8n1 busy end", 32'(busy1), 32'd1);
        tick();
        check_eq("8n1 busy drop", 32'(busy1), 32'd0);
        check_eq("8n1 tx idle", 32'(tx1), 32'd1);

        // Even parity 0x07 -> parity bit 1, 176 clocks
        send1(8'h07, 2'b01);
        check_frame(1, "even", 8'h07, 2'b01, 1, 1'b0);
        tick();
        check_eq("even busy drop", 32'(busy1), 32'd0);

        // Odd parity 0x07 -> parity bit 0
        send1(8'h07, 2'b10);
        check_frame(1, "odd", 8'h07, 2'b10, 1, 1'b0);
        tick();
        check_eq("odd busy drop", 32'(busy1), 32'd0);

        // FIFO fill, 2 stop bits, back-to-back frames
        d2 = 8'hA0; pm2 = 2'b00; v2 = 1'b1;
        tick();
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    d2 = 8'hA0 + 8'(i);
                    tick();
                end
                check_eq("fill ready low", 32'(rdy2), 32'd0);
                check_eq("fill count", 32'(cnt2), 32'd4);
                d2 = 8'hA5;
                tick();
                check_eq("fill 6th ignored", 32'(cnt2), 32'd4);
                v2 = 1'b0;
            end
            begin
                check_frame(2, "A0", 8'hA0, 2'b00, 2, 1'b0);
                check_eq("A0 end count", 32'(cnt2), 32'd4);
                check_eq("A0 end ready", 32'(rdy2), 32'd0);
                tick();
                check_eq("A1 pop count", 32'(cnt2), 32'd3);
                check_eq("A1 pop ready", 32'(rdy2), 32'd1);
                check_frame(2, "A1", 8'hA1, 2'b00, 2, 1'b1);
                for (int f = 2; f <= 4; f++)
                    check_frame(2, $sformatf("A%0d", f), 8'hA0 + 8'(f), 2'b00, 2, 1'b0);
            end
        join
        tick();
        check_eq("fill done busy", 32'(busy2), 32'd0);
        check_eq("fill done tx", 32'(tx2), 32'd1);
        check_eq("fill done count", 32'(cnt2), 32'd0);

        // Reset during data bit 3 with two words queued
        d1 = 8'hF0; pm1 = 2'b00; v1 = 1'b1;
        tick();
        d1 = 8'h11;
        tick();
        d1 = 8'h22;
        tick();
        v1 = 1'b0;
        check_eq("midrst queued", 32'(cnt1), 32'd2);
        repeat (67) tick();
        check_eq("midrst bit3 low", 32'(tx1), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("midrst tx", 32'(tx1), 32'd1);
        check_eq("midrst count", 32'(cnt1), 32'd0);
        check_eq("midrst busy", 32'(busy1), 32'd0);
        check_eq("midrst ready", 32'(rdy1), 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        check_eq("midrst silent", 32'(bad), 32'd0);
        send1(8'h3C, 2'b00);
        check_frame(1, "3C", 8'h3C, 2'b00, 1, 1'b0);
        tick();
        check_eq("3C busy drop", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
